// File: rtl/mem_resp_multiciclo_if.sv
// Request/response bundle between the multicycle control unit and the wait-state data memory.
interface mem_resp_multiciclo_if;
  logic        iLeMem;
  logic        iEscreveMem;
  logic [31:0] iEndereco;
  logic [31:0] iDadoEscrita;
  logic [2:0]  iFunct3;
  logic [31:0] oDadoLido;
  logic        oPronta;
  logic        oOcupado;
  logic        oErro;

  modport master (
    output iLeMem, iEscreveMem, iEndereco, iDadoEscrita, iFunct3,
    input  oDadoLido, oPronta, oOcupado, oErro
  );

  modport slave (
    input  iLeMem, iEscreveMem, iEndereco, iDadoEscrita, iFunct3,
    output oDadoLido, oPronta, oOcupado, oErro
  );
endinterface

// File: rtl/mem_resp_multiciclo.sv
// Data memory for a multicycle core: WAIT_CYCLES wait states, byte/half/word access, error completion.
// Completion (oPronta) arrives WAIT_CYCLES+2 cycles after the request edge; requests while busy are dropped.
module mem_resp_multiciclo #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic iCLK,
  input logic iRST,
  mem_resp_multiciclo_if.slave bus
);
  localparam int unsigned IDXW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {OCIOSO, ESPERA, ACESSO, CONCLUI} state_t;
  state_t state, nextState;

  logic [3:0]  waitCnt;
  logic        rLe, rEsc;
  logic [31:0] rAddr, rData;
  logic [2:0]  rF3;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdWord;

  logic            request;
  logic [31:0]     offset;
  logic            inRange, badAcc, err;
  logic [IDXW-1:0] wordIdx;
  logic [3:0]      byteEn;
  logic [31:0]     wrWord, shifted, fmtWord;

  assign request = bus.iLeMem | bus.iEscreveMem;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= OCIOSO;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      OCIOSO:  if (request) nextState = (WAIT_CYCLES > 0) ? ESPERA : ACESSO;
      ESPERA:  if (waitCnt == WAIT_LAST) nextState = ACESSO;
      ACESSO:  nextState = CONCLUI;
      CONCLUI: nextState = OCIOSO;
      default: nextState = OCIOSO;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      waitCnt <= 4'd0;
      rLe     <= 1'b0;
      rEsc    <= 1'b0;
      rAddr   <= 32'h0;
      rData   <= 32'h0;
      rF3     <= 3'b0;
    end else begin
      waitCnt <= (state == ESPERA && nextState == ESPERA) ? waitCnt + 4'd1 : 4'd0;
      if (state == OCIOSO && request) begin
        rLe   <= bus.iLeMem;
        rEsc  <= bus.iEscreveMem;
        rAddr <= bus.iEndereco;
        rData <= bus.iDadoEscrita;
        rF3   <= bus.iFunct3;
      end
    end
  end

  // Offset wraps below BASE_ADDR, so the lower bound is checked on the raw address.
  assign offset  = rAddr - BASE_ADDR;
  assign inRange = (rAddr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign wordIdx = offset[IDXW+1:2];

  always_comb begin
    badAcc = 1'b0;
    case (rF3)
      3'b000, 3'b100: badAcc = 1'b0;
      3'b001, 3'b101: badAcc = rAddr[0];
      3'b010:         badAcc = (rAddr[1:0] != 2'b00);
      default:        badAcc = 1'b1;
    endcase
  end

  assign err = (rLe & rEsc) | ~inRange | badAcc;

  always_comb begin
    byteEn = 4'b1111;
    wrWord = rData;
    case (rF3[1:0])
      2'b00: begin
        byteEn = 4'b0001 << rAddr[1:0];
        wrWord = {4{rData[7:0]}};
      end
      2'b01: begin
        byteEn = rAddr[1] ? 4'b1100 : 4'b0011;
        wrWord = {2{rData[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrWord = rData;
      end
    endcase
  end

  // Single-port synchronous RAM; deliberately outside the reset domain so contents survive iRST.
  always_ff @(posedge iCLK) begin
    if (state == ACESSO) begin
      if (rEsc && !err) begin
        for (int i = 0; i < 4; i++) begin
          if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wrWord[8*i +: 8];
        end
      end
      rdWord <= mem[wordIdx];
    end
  end

  always_comb begin
    shifted = rdWord >> {rAddr[1:0], 3'b000};
    fmtWord = rdWord;
    case (rF3[1:0])
      2'b00:   fmtWord = {{24{~rF3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   fmtWord = {{16{~rF3[2] & shifted[15]}}, shifted[15:0]};
      default: fmtWord = rdWord;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bus.oPronta   <= 1'b0;
      bus.oErro     <= 1'b0;
      bus.oOcupado  <= 1'b0;
      bus.oDadoLido <= 32'h0;
    end else begin
      bus.oPronta  <= (state == CONCLUI);
      bus.oErro    <= (state == CONCLUI) && err;
      bus.oOcupado <= (nextState != OCIOSO);
      if (state == CONCLUI && rLe && !err) bus.oDadoLido <= fmtWord;
    end
  end
endmodule

// File: tb/tb_mem_resp_multiciclo.sv
// Directed bench: main instance with 2 wait states at base 0, second instance with no wait states at base 0x100.
module tb_mem_resp_multiciclo;
  logic clk = 1'b0;
  logic rst2 = 1'b1;
  logic rst0 = 1'b1;
  always #5 clk = ~clk;

  mem_resp_multiciclo_if b2();
  mem_resp_multiciclo_if b0();

  mem_resp_multiciclo #(.WAIT_CYCLES(2), .DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000))
    dut2 (.iCLK(clk), .iRST(rst2), .bus(b2));
  mem_resp_multiciclo #(.WAIT_CYCLES(0), .DEPTH_WORDS(16), .BASE_ADDR(32'h0000_0100))
    dut0 (.iCLK(clk), .iRST(rst0), .bus(b0));

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic        err;
  logic        bsy;
  logic [31:0] dat;

  task automatic drive(input bit fast, input logic le, input logic esc,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    if (fast) begin
      b0.iLeMem = le; b0.iEscreveMem = esc; b0.iEndereco = a; b0.iDadoEscrita = d; b0.iFunct3 = f3;
    end else begin
      b2.iLeMem = le; b2.iEscreveMem = esc; b2.iEndereco = a; b2.iDadoEscrita = d; b2.iFunct3 = f3;
    end
  endtask

  // lat = posedges after the sampling edge until oPronta is seen high; -1 on timeout.
  task automatic req(input bit fast, input logic le, input logic esc,
                     input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    @(negedge clk);
    drive(fast, le, esc, a, d, f3);
    @(posedge clk);
    #1;
    drive(fast, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    bsy = fast ? b0.oOcupado : b2.oOcupado;
    lat = -1;
    err = 1'bx;
    dat = 32'hx;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (fast ? b0.oPronta : b2.oPronta) begin
        lat = c;
        err = fast ? b0.oErro : b2.oErro;
        dat = fast ? b0.oDadoLido : b2.oDadoLido;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    #1;
    checks++; if (b2.oPronta !== 1'b0) begin errors++; $display("FAIL reset_pronta got=%b exp=0", b2.oPronta); end
    checks++; if (b2.oErro !== 1'b0) begin errors++; $display("FAIL reset_erro got=%b exp=0", b2.oErro); end
    checks++; if (b2.oOcupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got=%b exp=0", b2.oOcupado); end
    checks++; if (b2.oDadoLido !== 32'h0) begin errors++; $display("FAIL reset_dado got=%h exp=00000000", b2.oDadoLido); end
    checks++; if (b0.oPronta !== 1'b0) begin errors++; $display("FAIL reset_pronta_w0 got=%b exp=0", b0.oPronta); end
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    rst0 = 1'b0;
  endtask

  task automatic test_word();
    req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010);
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL sw_busy got=%b exp=1", bsy); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL sw_latency got=%0d exp=4", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_erro got=%b exp=0", err); end
    checks++; if (dat !== 32'h0) begin errors++; $display("FAIL sw_keeps_dado got=%h exp=00000000", dat); end
    @(posedge clk); #1;
    checks++; if (b2.oPronta !== 1'b0) begin errors++; $display("FAIL pronta_one_cycle got=%b exp=0", b2.oPronta); end
    checks++; if (b2.oOcupado !== 1'b0) begin errors++; $display("FAIL idle_after got=%b exp=0", b2.oOcupado); end
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lw_latency got=%0d exp=4", lat); end
    checks++; if (dat !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", dat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_erro got=%b exp=0", err); end
  endtask

  task automatic test_subword_loads();
    req(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b000);
    checks++; if (dat !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb got=%h exp=ffffffde", dat); end
    req(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 3'b100);
    checks++; if (dat !== 32'h000000DE) begin errors++; $display("FAIL lbu got=%h exp=000000de", dat); end
    req(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b001);
    checks++; if (dat !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh got=%h exp=ffffdead", dat); end
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b101);
    checks++; if (dat !== 32'h0000BEEF) begin errors++; $display("FAIL lhu got=%h exp=0000beef", dat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lhu_erro got=%b exp=0", err); end
  endtask

  task automatic test_subword_stores();
    req(1'b0, 1'b0, 1'b1, 32'h11, 32'h00000055, 3'b000);
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    checks++; if (dat !== 32'hDEAD55EF) begin errors++; $display("FAIL sb_lane got=%h exp=dead55ef", dat); end
    req(1'b0, 1'b0, 1'b1, 32'h14, 32'h11223344, 3'b010);
    req(1'b0, 1'b0, 1'b1, 32'h16, 32'h9999CAFE, 3'b001);
    req(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 3'b010);
    checks++; if (dat !== 32'hCAFE3344) begin errors++; $display("FAIL sh_upper got=%h exp=cafe3344", dat); end
  endtask

  task automatic test_errors();
    req(1'b0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b010);
    checks++; if (err !== 1'b1 || lat !== 4) begin errors++; $display("FAIL lw_misaligned erro=%b lat=%0d exp erro=1 lat=4", err, lat); end
    checks++; if (dat !== 32'hCAFE3344) begin errors++; $display("FAIL err_keeps_dado got=%h exp=cafe3344", dat); end
    req(1'b0, 1'b0, 1'b1, 32'h11, 32'h0000FFFF, 3'b001);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sh_misaligned erro=%b exp=1", err); end
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b011);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL funct3_011 erro=%b exp=1", err); end
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b110);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL funct3_110 erro=%b exp=1", err); end
    req(1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 3'b010);
    checks++; if (err !== 1'b1 || dat !== 32'hCAFE3344) begin errors++; $display("FAIL both_req erro=%b dado=%h exp erro=1 dado=cafe3344", err, dat); end
    req(1'b0, 1'b0, 1'b1, 32'h400, 32'h12345678, 3'b010);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sw_out_of_range erro=%b exp=1", err); end
    req(1'b0, 1'b1, 1'b0, 32'h3FC, 32'h0, 3'b010);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lw_last_word erro=%b exp=0", err); end
    req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    checks++; if (dat !== 32'hDEAD55EF) begin errors++; $display("FAIL ram_untouched got=%h exp=dead55ef", dat); end
  endtask

  task automatic test_reset_abort();
    int seen;
    req(1'b0, 1'b0, 1'b1, 32'h20, 32'h01020304, 3'b010);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_prior erro=%b exp=0", err); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hBADBAD00, 3'b010);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
    @(posedge clk); #2;
    rst2 = 1'b1;
    #1;
    checks++; if (b2.oOcupado !== 1'b0 || b2.oDadoLido !== 32'h0) begin
      errors++; $display("FAIL abort_reset_outputs ocupado=%b dado=%h exp 0/00000000", b2.oOcupado, b2.oDadoLido);
    end
    #1;
    rst2 = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (b2.oPronta === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_pronta pulses=%0d exp=0", seen); end
    req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    checks++; if (dat !== 32'h01020304) begin errors++; $display("FAIL abort_no_write got=%h exp=01020304", dat); end
  endtask

  task automatic test_busy_zero_wait();
    int first, pulses;
    req(1'b1, 1'b0, 1'b1, 32'h104, 32'hA5A5A5A5, 3'b010);
    checks++; if (lat !== 2 || err !== 1'b0) begin errors++; $display("FAIL w0_latency lat=%0d erro=%b exp lat=2 erro=0", lat, err); end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h108, 32'h11111111, 3'b010);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'h108, 32'h22222222, 3'b010);
    first = -1;
    pulses = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 2) drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b0);
      if (b0.oPronta === 1'b1) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checks++; if (first !== 2 || pulses !== 1) begin errors++; $display("FAIL busy_ignored first=%0d pulses=%0d exp first=2 pulses=1", first, pulses); end
    req(1'b1, 1'b1, 1'b0, 32'h108, 32'h0, 3'b010);
    checks++; if (dat !== 32'h11111111) begin errors++; $display("FAIL busy_no_overwrite got=%h exp=11111111", dat); end
    req(1'b1, 1'b1, 1'b0, 32'hFC, 32'h0, 3'b010);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL below_base erro=%b exp=1", err); end
    req(1'b1, 1'b1, 1'b0, 32'h140, 32'h0, 3'b010);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL above_top erro=%b exp=1", err); end
    req(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 3'b010);
    checks++; if (err !== 1'b0 || dat !== 32'hA5A5A5A5) begin errors++; $display("FAIL w0_readback erro=%b dado=%h exp 0/a5a5a5a5", err, dat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_loads();
    test_subword_stores();
    test_errors();
    test_reset_abort();
    test_busy_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_resp_multiciclo.md
MEM_RESP_MULTICICLO -- requirements
Module: mem_resp_multiciclo

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access (0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning RAM size in 32-bit words (power of two).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-004 SHALL have port iCLK, input, 1, system clock (rising edge).
REQ-005 SHALL have port iRST, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port iLeMem, input, 1, read request from the multicycle control.
REQ-007 SHALL have port iEscreveMem, input, 1, write request from the multicycle control.
REQ-008 SHALL have port iEndereco, input, 32, byte address.
REQ-009 SHALL have port iDadoEscrita, input, 32, store data, right-aligned.
REQ-010 SHALL have port iFunct3, input, 3, access size: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-011 SHALL have port oDadoLido, output, 32, formatted read data.
REQ-012 SHALL have port oPronta, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port oOcupado, output, 1, high whenever the FSM is not in OCIOSO.
REQ-014 SHALL have port oErro, output, 1, one-cycle error pulse, coincident with oPronta.

Function
REQ-015 SHALL implement FSM states OCIOSO, ESPERA, ACESSO, CONCLUI.
REQ-016 In OCIOSO, a rising iCLK with iLeMem or iEscreveMem high SHALL latch iEndereco, iDadoEscrita, iFunct3 and the request type.
- Next state: ESPERA if WAIT_CYCLES>0, else ACESSO.
REQ-017 ESPERA SHALL count WAIT_CYCLES cycles, then go to ACESSO.
REQ-018 ACESSO SHALL perform the RAM read or write in exactly one cycle, then go to CONCLUI.
REQ-019 CONCLUI SHALL assert oPronta for one cycle, then return to OCIOSO.
REQ-020 Latency: for a request sampled at edge N, oPronta SHALL be high during cycle N+WAIT_CYCLES+2.
REQ-021 Requests arriving while oOcupado=1 SHALL be ignored; no queueing.
REQ-022 iLeMem and iEscreveMem both high at sampling SHALL produce an error completion, with no RAM write.
REQ-023 Addressing: word index = (addr-BASE_ADDR)>>2, little-endian byte lanes.
- Address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) SHALL produce an error.
REQ-024 Alignment: half with addr[0]=1, word with addr[1:0]!=00, or funct3 in {011,110,111} SHALL produce an error.
REQ-025 Error completion SHALL pulse oErro with oPronta, SHALL NOT modify RAM, and SHALL leave oDadoLido unchanged.
REQ-026 Stores SHALL write only the addressed lanes:
- sb: lane addr[1:0] takes data[7:0].
- sh: lanes 2*addr[1] and 2*addr[1]+1 take data[15:0].
- sw: all lanes.
REQ-027 Loads SHALL right-align the addressed lanes.
- Sign-extend for 000/001, zero-extend for 100/101.
- Update oDadoLido in CONCLUI; hold it until the next successful read.
REQ-028 Writes SHALL NOT alter oDadoLido.
REQ-029 Outputs SHALL be registered; RAM SHALL be synchronous single-port.

Reset
REQ-030 On iRST high, state SHALL go to OCIOSO immediately; oPronta=0, oErro=0, oOcupado=0, oDadoLido=32'h0, wait counter=0.
REQ-031 Reset during ESPERA SHALL abort the request: no write is committed and no oPronta is produced.
REQ-032 RAM contents SHALL NOT be cleared by reset.

Verification
REQ-033 sw 0xDEADBEEF @0x10, then lw @0x10 with WAIT_CYCLES=2 -> oPronta 4 cycles after each sample; oDadoLido=0xDEADBEEF; oErro=0.
REQ-034 After REQ-033: lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD; lhu @0x10 -> 0x0000BEEF.
REQ-035 sb 0x55 @0x11, then lw @0x10 -> 0xDEAD55EF.
REQ-036 lw @0x12, sh @0x11, funct3=011, and both requests high -> each gives oPronta=oErro=1, RAM unchanged, oDadoLido unchanged.
REQ-037 sw @0x20 with iRST pulsed in ESPERA -> no oPronta; a later lw @0x20 returns the prior contents.
REQ-038 Second request held high while oOcupado=1 -> ignored; with WAIT_CYCLES=0, oPronta exactly 2 cycles after sampling.
